// File: rtl/tff_mod_counter_pkg.sv
// tff_mod_counter_pkg: direction constants and modulo count helpers
package tff_mod_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic int clamp_load(int d, int modulus);
    return d > modulus - 1 ? modulus - 1 : d;
  endfunction
  function automatic int next_count(int q, logic up, int modulus);
    return up == DIR_UP ? (q >= modulus - 1 ? 0 : q + 1)
                        : ((q == 0 || q > modulus - 1) ? modulus - 1 : q - 1);
  endfunction
endpackage

// File: rtl/tff_mod_counter_cell.sv
// tff_cell: single T flip-flop with synchronous active-high reset
module tff_cell (
  input  logic Clock,
  input  logic Reset,
  input  logic T,
  output logic Q,
  output logic Qb
);
  // toggle on T, clear on Reset
  always_ff @(posedge Clock)
    if (Reset) Q <= 1'b0;
    else Q <= Q ^ T;
  assign Qb = ~Q;
endmodule

// File: rtl/tff_mod_counter.sv
// tff_mod_counter: modulo-N up/down counter built from T flip-flop cells
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             TC
);
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS out of range");
  end
  logic [WIDTH-1:0] nxt, t;
  logic wrap;
  // next count: load clamps, count wraps modulo MODULUS; each cell toggles where next differs
  always_comb begin
    nxt = Load ? WIDTH'(clamp_load(int'(D), MODULUS))
        : En ? WIDTH'(next_count(int'(Q), Up, MODULUS)) : Q;
    t = Q ^ nxt;
    wrap = !Load && En && (Up == DIR_UP ? int'(Q) == MODULUS - 1 : Q == '0);
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (.Clock(Clock), .Reset(Reset), .T(t[i]), .Q(Q[i]), .Qb(Qb[i]));
  end
  // terminal-count pulse registered alongside the wrapped value
  always_ff @(posedge Clock)
    if (Reset) TC <= 1'b0;
    else TC <= wrap;
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter: directed and random checks against an arithmetic model
module tb_tff_mod_counter;
  localparam int M = 10;
  localparam int M2 = 8;
  logic clk = 1'b0;
  logic reset, load, en, up;
  logic [3:0] d, q, qb;
  logic tc;
  logic en2, up2;
  logic [2:0] q2, qb2;
  logic tc2;
  int q_m, q2_m, tc_m, tc2_m;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  tff_mod_counter #(.WIDTH(4), .MODULUS(M)) dut (
    .Clock(clk), .Reset(reset), .En(en), .Up(up), .Load(load), .D(d),
    .Q(q), .Qb(qb), .TC(tc));
  tff_mod_counter #(.WIDTH(3), .MODULUS(M2)) dut2 (
    .Clock(clk), .Reset(reset), .En(en2), .Up(up2), .Load(1'b0), .D(3'd0),
    .Q(q2), .Qb(qb2), .TC(tc2));
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask
  task automatic step(bit r, bit l, bit e, bit u, int dd);
    int old2, exp_t, p;
    reset = r; load = l; en = e; up = u; d = 4'(dd);
    en2 = 1'($urandom); up2 = 1'($urandom);
    old2 = q2_m;
    @(posedge clk);
    tc_m = 0;
    if (r) q_m = 0;
    else if (l) q_m = dd > M - 1 ? M - 1 : dd;
    else if (e && u) begin tc_m = q_m == M - 1; q_m = (q_m + 1) % M; end
    else if (e) begin tc_m = q_m == 0; q_m = (q_m + M - 1) % M; end
    tc2_m = 0;
    if (r) q2_m = 0;
    else if (en2) begin
      tc2_m = up2 ? q2_m == M2 - 1 : q2_m == 0;
      q2_m = up2 ? (q2_m + 1) % M2 : (q2_m + M2 - 1) % M2;
    end
    #1;
    chk("q", q, q_m);
    chk("qb", qb, (~q_m) & 15);
    chk("tc", tc, tc_m);
    chk("q2", q2, q2_m);
    chk("qb2", qb2, (~q2_m) & 7);
    chk("tc2", tc2, tc2_m);
    if (!r && en2) begin
      exp_t = 0;
      for (int i = 0; i < 3; i++) begin
        p = 1 << i;
        if (up2 ? (old2 % p == p - 1) : (old2 % p == 0)) exp_t |= p;
      end
      chk("t2_ripple", int'(q2) ^ old2, exp_t);
    end
  endtask
  initial begin
    q_m = 0; q2_m = 0; tc_m = 0; tc2_m = 0;
    step(1, 1, 1, 1, 5);
    step(1, 1, 1, 1, 5);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 7);
    step(0, 1, 0, 0, 12);
    step(0, 1, 0, 0, 9);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 9);
    step(1, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
           1'($urandom), int'($urandom_range(15)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
